// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM state type, default operand width and small op-decode helpers.
// The divider datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True for DIV/DIVU.
  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  // True for the signed variants MULT/DIV.
  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on a 2*WIDTH accumulator (multiplier in the low half,
// partial product growing in the high half).
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract, remainder in the
// high half, dividend shifting out / quotient shifting in on the low half.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic                 is_div,
`endif
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   mul_out;

  // Shift-add: conditionally add the multiplicand to the high half, then shift right.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_out = {sum, acc_in[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_out;

  // Restoring divide: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (!diff[WIDTH]) begin
      div_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end else begin
      div_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

  // Select the datapath for the operation in flight.
  always_comb begin
    acc_out = is_div ? div_out : mul_out;
  end
`else
  // Only the multiplier exists in this build.
  always_comb begin
    acc_out = mul_out;
  end
`endif

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit sitting in EX behind the ID/EX register.
// Computes HI:LO for MULT/MULTU/DIV/DIVU in WIDTH iterations while holding
// the front of the pipeline with stall_req. Define MULDIV_DIV_EN to include
// the divider; without it, divide ops retire in one cycle leaving HI/LO alone.
//
// Handshake: start is a level request from the EX instruction. It is taken
// in IDLE when done is low and flush is low; from then until the result
// cycle stall_req is high and ID/EX is frozen, so start stays high. done is
// a one-cycle pulse with HI/LO valid; stall_req is low in that cycle so the
// instruction leaves EX, and the still-high start in that cycle is ignored.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               sign_p;     // product sign (mult) or quotient sign (div)

  logic               accept;
  logic               op_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic               is_div;
  logic               sign_r;     // remainder sign follows the dividend
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  // Operand magnitudes, acceptance and pipeline-hold decode.
  always_comb begin
    op_signed = op_is_signed(op);
    sign_a    = op_signed & src_a[WIDTH-1];
    sign_b    = op_signed & src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
    accept    = (state == IDLE) & start & ~done & ~flush;
    stall_req = (state == BUSY) | accept;
    busy      = (state == BUSY);
  end

  muldiv_step #(
    .WIDTH   (WIDTH)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (is_div),
`endif
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_step)
  );

  // Sign correction of the final iteration's result.
  always_comb begin
    prod_fix = sign_p ? -acc_step : acc_step;
`ifdef MULDIV_DIV_EN
    quot_fix = sign_p ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = sign_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
`endif
  end

  // Control FSM plus iteration registers and the architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opnd        <= '0;
      sign_p      <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        // Squash: drop whatever is in flight, HI/LO keep the last result.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (op_is_div(op)) begin
`ifdef MULDIV_DIV_EN
                if (src_b == '0) begin
                  hi_out      <= src_a;
                  lo_out      <= '1;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  state  <= BUSY;
                  count  <= CW'(WIDTH);
                  acc    <= {{WIDTH{1'b0}}, mag_a};
                  opnd   <= mag_b;
                  is_div <= 1'b1;
                  sign_p <= sign_a ^ sign_b;
                  sign_r <= sign_a;
                end
`else
                done <= 1'b1;
`endif
              end else begin
                state  <= BUSY;
                count  <= CW'(WIDTH);
                acc    <= {{WIDTH{1'b0}}, mag_b};
                opnd   <= mag_a;
                sign_p <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
                is_div <= 1'b0;
                sign_r <= 1'b0;
`endif
              end
            end
          end
          BUSY: begin
            acc   <= acc_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
`ifdef MULDIV_DIV_EN
              if (is_div) begin
                hi_out <= rem_fix;
                lo_out <= quot_fix;
              end else
`endif
              begin
                {hi_out, lo_out} <= prod_fix;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
